// File: rtl/rv_mem_mt.sv
// rv_mem_mt - dual-port unified instruction/data memory for a barrel-threaded core.
//
// Purpose:
//   One word array shared by a fetch port (A) and a load/store port (B).
//   Both ports use a req/ready -> valid handshake with one cycle of latency
//   and carry a hardware-thread tag alongside the registered response.
//   After reset the array is zero-filled through port B, one word per cycle,
//   before any request is accepted.
//
// Build option:
//   RV_MEM_MT_FWD_EN - when defined, a fetch that hits the word being stored
//                      by port B in the same cycle returns the merged new word.
//                      When undefined, the fetch returns the pre-write word.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   init_done                  high once the zero-fill is complete
//   i_req/i_tid/i_addr         fetch request, thread tag, byte address
//   i_ready                    fetch accept (equals init_done)
//   i_valid/i_tid_out/code_out fetch response, tag, word
//   d_req/d_we/d_size/d_unsigned/d_tid/d_addr/d_in
//                              data request: store/load, size (00 B, 01 H, 10 W),
//                              zero-extend select, tag, byte address, store data
//   d_ready                    data accept (equals init_done)
//   d_valid/d_tid_out/d_out/d_err
//                              data response, tag, load result, error flag
//
// Only DATA_WIDTH = 32 (four byte lanes) is supported.

module rv_mem_mt #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int NUM_THREADS = 4,
    localparam int TID_W      = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_done,

    input  logic                  i_req,
    input  logic [TID_W-1:0]      i_tid,
    input  logic [DATA_WIDTH-1:0] i_addr,
    output logic                  i_ready,
    output logic                  i_valid,
    output logic [TID_W-1:0]      i_tid_out,
    output logic [DATA_WIDTH-1:0] code_out,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [1:0]            d_size,
    input  logic                  d_unsigned,
    input  logic [TID_W-1:0]      d_tid,
    input  logic [DATA_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic                  d_ready,
    output logic                  d_valid,
    output logic [TID_W-1:0]      d_tid_out,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic                  d_err
);

    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int NUM_LANES = DATA_WIDTH / 8;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   init_cnt_reg, init_cnt_next;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // ------------------------------------------------------------------
    // Zero-fill sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_INIT;
            init_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        if (state_reg == ST_INIT) begin
            init_cnt_next = init_cnt_reg + 1'b1;
            if (init_cnt_reg == {ADDR_WIDTH{1'b1}}) begin
                state_next = ST_RUN;
            end
        end
    end

    assign init_done = (state_reg == ST_RUN);
    assign i_ready   = init_done;
    assign d_ready   = init_done;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic                  a_fire;
    logic                  d_fire;
    logic [ADDR_WIDTH-1:0] a_idx;
    logic [ADDR_WIDTH-1:0] d_idx;
    logic [1:0]            d_off;
    logic                  d_bad;
    logic [NUM_LANES-1:0]  d_be;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_store;

    assign a_fire = i_req & init_done;
    assign d_fire = d_req & init_done;
    assign a_idx  = i_addr[ADDR_WIDTH+1:2];
    assign d_idx  = d_addr[ADDR_WIDTH+1:2];
    assign d_off  = d_addr[1:0];

    // Store data is replicated across lanes so the byte enables alone pick
    // where it lands.
    always_comb begin
        d_bad   = 1'b0;
        d_be    = '0;
        d_wdata = d_in;
        case (d_size)
            2'b00: begin
                d_be    = 4'b0001 << d_off;
                d_wdata = {4{d_in[7:0]}};
            end
            2'b01: begin
                d_wdata = {2{d_in[15:0]}};
                if (d_off[0]) begin
                    d_bad = 1'b1;
                end else begin
                    d_be = d_off[1] ? 4'b1100 : 4'b0011;
                end
            end
            2'b10: begin
                if (d_off != 2'b00) begin
                    d_bad = 1'b1;
                end else begin
                    d_be = 4'b1111;
                end
            end
            default: d_bad = 1'b1;
        endcase
    end

    assign d_store = d_fire & d_we & ~d_bad;

    // ------------------------------------------------------------------
    // Array write port (shared by zero-fill and stores)
    // ------------------------------------------------------------------
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [NUM_LANES-1:0]  wr_be;
    logic [DATA_WIDTH-1:0] wr_data;

    assign wr_en   = (state_reg == ST_INIT) | d_store;
    assign wr_idx  = (state_reg == ST_INIT) ? init_cnt_reg : d_idx;
    assign wr_be   = (state_reg == ST_INIT) ? {NUM_LANES{1'b1}} : d_be;
    assign wr_data = (state_reg == ST_INIT) ? '0 : d_wdata;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (wr_be[i]) begin
                    mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Port A read (optionally merged with a same-cycle store)
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] a_rd_word;

`ifdef RV_MEM_MT_FWD_EN
    logic fwd_hit;
    assign fwd_hit = d_store && (d_idx == a_idx);

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_fwd_lane
            assign a_rd_word[gi*8 +: 8] = (fwd_hit && d_be[gi]) ? d_wdata[gi*8 +: 8]
                                                                 : mem[a_idx][gi*8 +: 8];
        end
    endgenerate
`else
    assign a_rd_word = mem[a_idx];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_valid   <= 1'b0;
            i_tid_out <= '0;
            code_out  <= '0;
        end else begin
            i_valid <= a_fire;
            if (a_fire) begin
                i_tid_out <= i_tid;
                code_out  <= a_rd_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Port B load path: align the selected lanes to bit 0 and extend
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] d_rd_word;
    logic [DATA_WIDTH-1:0] d_shift;
    logic [DATA_WIDTH-1:0] d_load;
    logic [DATA_WIDTH-1:0] d_result;

    assign d_rd_word = mem[d_idx];
    assign d_shift   = d_rd_word >> {d_off, 3'b000};

    always_comb begin
        d_load = '0;
        case (d_size)
            2'b00:   d_load = d_unsigned ? {24'h0, d_shift[7:0]}
                                         : {{24{d_shift[7]}}, d_shift[7:0]};
            2'b01:   d_load = d_unsigned ? {16'h0, d_shift[15:0]}
                                         : {{16{d_shift[15]}}, d_shift[15:0]};
            2'b10:   d_load = d_shift;
            default: d_load = '0;
        endcase
    end

    // Stores and faulting accesses return zero data.
    assign d_result = (d_we | d_bad) ? '0 : d_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_valid   <= 1'b0;
            d_tid_out <= '0;
            d_out     <= '0;
            d_err     <= 1'b0;
        end else begin
            d_valid <= d_fire;
            if (d_fire) begin
                d_tid_out <= d_tid;
                d_out     <= d_result;
                d_err     <= d_bad;
            end
        end
    end

    // Address bits outside the word index do not select anything.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[DATA_WIDTH-1:ADDR_WIDTH+2], i_addr[1:0],
                                d_addr[DATA_WIDTH-1:ADDR_WIDTH+2]};

endmodule

// File: tb/tb_rv_mem_mt.sv
// Testbench for rv_mem_mt (ADDR_WIDTH = 4, four threads).
// Requests are driven from a sequencer that pushes expected responses into
// per-port queues using a byte-addressed reference model; a monitor on the
// falling edge pops and compares whenever a response is due.

module tb_rv_mem_mt;

    localparam int AW     = 4;
    localparam int NBYTES = (1 << AW) * 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_done;
    logic        i_req = 1'b0;
    logic [1:0]  i_tid = '0;
    logic [31:0] i_addr = '0;
    logic        i_ready, i_valid;
    logic [1:0]  i_tid_out;
    logic [31:0] code_out;
    logic        d_req = 1'b0, d_we = 1'b0, d_unsigned = 1'b0;
    logic [1:0]  d_size = '0;
    logic [1:0]  d_tid = '0;
    logic [31:0] d_addr = '0, d_in = '0;
    logic        d_ready, d_valid, d_err;
    logic [1:0]  d_tid_out;
    logic [31:0] d_out;

    rv_mem_mt #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .NUM_THREADS(4)) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .i_req(i_req), .i_tid(i_tid), .i_addr(i_addr), .i_ready(i_ready),
        .i_valid(i_valid), .i_tid_out(i_tid_out), .code_out(code_out),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
        .d_tid(d_tid), .d_addr(d_addr), .d_in(d_in), .d_ready(d_ready),
        .d_valid(d_valid), .d_tid_out(d_tid_out), .d_out(d_out), .d_err(d_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          due;
        logic [1:0]  tid;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t       qa[$];
    exp_t       qb[$];
    logic [7:0] mem_m [NBYTES];
    bit         model_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (byte addressed) ----------------
    function automatic logic [31:0] model_fetch(input logic [31:0] addr);
        int a;
        logic [31:0] w;
        a = int'(addr[AW+1:2]) * 4;
        w = '0;
        for (int j = 0; j < 4; j++) w[8*j +: 8] = mem_m[a+j];
        return w;
    endfunction

    function automatic void model_b(input bit we, input logic [1:0] sz, input bit un,
                                    input logic [31:0] addr, input logic [31:0] din,
                                    output logic [31:0] data, output logic err);
        int a, n;
        a    = int'(addr[AW+1:0]);
        n    = 1 << sz;
        err  = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00);
        data = '0;
        if (!err) begin
            if (we) begin
                for (int j = 0; j < n; j++) mem_m[a+j] = din[8*j +: 8];
            end else begin
                for (int j = 0; j < n; j++) data[8*j +: 8] = mem_m[a+j];
                if (!un && n < 4 && data[8*n-1]) data = data | ~((32'd1 << (8*n)) - 32'd1);
            end
        end
    endfunction

    // ---------------- monitor ----------------
    logic [31:0] last_code = '0;
    logic [31:0] last_d    = '0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_code = '0;
            last_d    = '0;
        end else begin
            if (qa.size() > 0 && qa[0].due == cyc) begin
                e = qa.pop_front();
                check("i_valid", i_valid, 1);
                check("i_tid_out", i_tid_out, e.tid);
                check("code_out", code_out, e.data);
                $display("A cyc=%0d tid=%0d code=%08h exp=%08h", cyc, i_tid_out, code_out, e.data);
                last_code = e.data;
            end else begin
                check("i_valid idle", i_valid, 0);
                check("code_out hold", code_out, last_code);
            end
            if (qb.size() > 0 && qb[0].due == cyc) begin
                e = qb.pop_front();
                check("d_valid", d_valid, 1);
                check("d_tid_out", d_tid_out, e.tid);
                check("d_out", d_out, e.data);
                check("d_err", d_err, e.err);
                $display("B cyc=%0d tid=%0d d_out=%08h err=%0d exp=%08h/%0d",
                         cyc, d_tid_out, d_out, d_err, e.data, e.err);
                last_d = e.data;
            end else begin
                check("d_valid idle", d_valid, 0);
                check("d_out hold", d_out, last_d);
            end
        end
    end

    // ---------------- sequencer ----------------
    // Called at posedge+1; drives one cycle of requests and returns at the
    // next posedge+1.
    task automatic drive(input bit ar, input logic [1:0] at, input logic [31:0] aa,
                         input bit dr, input bit we, input logic [1:0] sz, input bit un,
                         input logic [1:0] dt, input logic [31:0] da, input logic [31:0] din);
        exp_t ea, eb;
        i_req = ar; i_tid = at; i_addr = aa;
        d_req = dr; d_we = we; d_size = sz; d_unsigned = un; d_tid = dt; d_addr = da; d_in = din;
        check("i_ready", i_ready, model_ready);
        check("d_ready", d_ready, model_ready);
        if (model_ready) begin
            ea.due = cyc + 1; ea.tid = at; ea.err = 1'b0; ea.data = '0;
            eb.due = cyc + 1; eb.tid = dt; eb.err = 1'b0; eb.data = '0;
`ifdef RV_MEM_MT_FWD_EN
            if (dr) model_b(we, sz, un, da, din, eb.data, eb.err);
            if (ar) ea.data = model_fetch(aa);
`else
            if (ar) ea.data = model_fetch(aa);
            if (dr) model_b(we, sz, un, da, din, eb.data, eb.err);
`endif
            if (ar) qa.push_back(ea);
            if (dr) qb.push_back(eb);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    // Releases reset (while issuing requests that must be dropped) and checks
    // that init_done rises exactly 2^AW edges later. Returns at posedge+1.
    task automatic release_and_init();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= (1 << AW); i++) begin
            i_req = 1'b1; i_tid = 2'($urandom); i_addr = $urandom;
            d_req = 1'b1; d_we = 1'b1; d_size = 2'd2; d_tid = 2'($urandom);
            d_addr = {$urandom} & 32'hFFFF_FFFC; d_in = $urandom;
            check("i_ready init", i_ready, 0);
            @(posedge clk);
            #1;
            check("init_done timing", init_done, (i == (1 << AW)) ? 1 : 0);
        end
        idle_inputs();
        for (int j = 0; j < NBYTES; j++) mem_m[j] = 8'h00;
        model_ready = 1'b1;
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        idle_inputs();
        qa.delete();
        qb.delete();
        model_ready = 1'b0;
        #1;
        check("rst i_valid", i_valid, 0);
        check("rst d_valid", d_valid, 0);
        check("rst init_done", init_done, 0);
        check("rst code_out", code_out, 0);
        check("rst d_out", d_out, 0);
        check("rst d_err", d_err, 0);
        repeat (3) @(posedge clk);
        release_and_init();
    endtask

    task automatic rand_ops(input int n);
        bit          ar, dr, we, un;
        logic [1:0]  at, dt, sz;
        logic [31:0] aa, da, din;
        for (int k = 0; k < n; k++) begin
            ar  = bit'($urandom_range(0, 1));
            dr  = bit'($urandom_range(0, 3) != 0);
            we  = bit'($urandom_range(0, 1));
            un  = bit'($urandom_range(0, 1));
            at  = 2'($urandom);
            dt  = 2'($urandom);
            sz  = 2'($urandom_range(0, 3));
            din = $urandom;
            da  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, NBYTES - 1));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) da[0] = 1'b0;
                if (sz == 2'd2) da[1:0] = 2'b00;
            end
            aa  = ($urandom_range(0, 3) == 0) ? da : $urandom;
            drive(ar, at, aa, dr, we, sz, un, dt, da, din);
        end
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check("reset init_done", init_done, 0);
        check("reset i_ready", i_ready, 0);
        check("reset d_ready", d_ready, 0);
        check("reset i_valid", i_valid, 0);
        check("reset d_valid", d_valid, 0);
        check("reset d_err", d_err, 0);
        check("reset i_tid_out", i_tid_out, 0);
        check("reset d_tid_out", d_tid_out, 0);
        check("reset code_out", code_out, 0);
        check("reset d_out", d_out, 0);

        release_and_init();

        // Directed scenarios
        drive(1, 2'd1, 32'h3C, 0, 0, 2'd0, 0, 2'd0, 32'h0, 32'h0);                // fetch zeroed word
        drive(0, 2'd0, 32'h0, 1, 1, 2'd2, 0, 2'd0, 32'h10, 32'hDEADBEEF);          // store word
        drive(0, 2'd0, 32'h0, 1, 0, 2'd0, 0, 2'd1, 32'h13, 32'h0);                 // lb  0x13
        drive(0, 2'd0, 32'h0, 1, 0, 2'd1, 1, 2'd2, 32'h10, 32'h0);                 // lhu 0x10
        drive(0, 2'd0, 32'h0, 1, 1, 2'd0, 0, 2'd3, 32'h11, 32'h5A);                // sb  0x11
        drive(0, 2'd0, 32'h0, 1, 0, 2'd2, 0, 2'd0, 32'h10, 32'h0);                 // lw
        drive(0, 2'd0, 32'h0, 1, 1, 2'd1, 0, 2'd1, 32'h11, 32'hFFFF);              // misaligned sh
        drive(0, 2'd0, 32'h0, 1, 0, 2'd2, 0, 2'd2, 32'h10, 32'h0);                 // lw unchanged
        drive(0, 2'd0, 32'h0, 1, 0, 2'd3, 0, 2'd3, 32'h10, 32'h0);                 // reserved size
        for (int t = 0; t < 4; t++)
            drive(1, 2'(t), 32'h10 + 32'(4 * t), 0, 0, 2'd0, 0, 2'd0, 32'h0, 32'h0);
        drive(1, 2'd2, 32'h20, 1, 1, 2'd2, 0, 2'd3, 32'h20, 32'h11223344);         // same-cycle hit
        drive(1, 2'd3, 32'h20, 0, 0, 2'd0, 0, 2'd0, 32'h0, 32'h0);
        drive(0, 2'd0, 32'h0, 0, 0, 2'd0, 0, 2'd0, 32'h0, 32'h0);

        rand_ops(400);
        mid_reset();
        drive(1, 2'd0, 32'h10, 1, 0, 2'd2, 0, 2'd1, 32'h10, 32'h0);                // contents re-zeroed
        rand_ops(200);

        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("qa drained", 32'(qa.size()), 0);
        check("qb drained", 32'(qb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
